// File: rtl/ftsd_pkg.sv
// ---------------------------------------------------------------------------
// ftsd_pkg
// Shared widths and fourteen-segment glyphs for the score display path.
// All glyphs are active-low: a 0 bit lights the segment, 1 leaves it dark.
//
// Bit map of the 15-bit segment bus:
//   [0] a (top)      [1] b (upper right)  [2] c (lower right)  [3] d (bottom)
//   [4] e (lower left) [5] f (upper left) [6] g1 (mid left)   [7] g2 (mid right)
//   [13:8] diagonals / centre verticals (unused by digits)     [14] dp
// ---------------------------------------------------------------------------
package ftsd_pkg;

    localparam int FTSD_W = 15;
    localparam int DIGITS = 4;

    localparam logic [FTSD_W-1:0] SEG_A  = 15'h0001;
    localparam logic [FTSD_W-1:0] SEG_B  = 15'h0002;
    localparam logic [FTSD_W-1:0] SEG_C  = 15'h0004;
    localparam logic [FTSD_W-1:0] SEG_D  = 15'h0008;
    localparam logic [FTSD_W-1:0] SEG_E  = 15'h0010;
    localparam logic [FTSD_W-1:0] SEG_F  = 15'h0020;
    localparam logic [FTSD_W-1:0] SEG_G1 = 15'h0040;
    localparam logic [FTSD_W-1:0] SEG_G2 = 15'h0080;

    // Inverting the lit-segment mask gives the active-low pattern with every
    // unused segment (diagonals, dp) held dark.
    localparam logic [FTSD_W-1:0] FTSD_BLANK = 15'h7FFF;
    localparam logic [FTSD_W-1:0] FTSD_DASH  = ~(SEG_G1 | SEG_G2);
    localparam logic [FTSD_W-1:0] FTSD_0 = ~(SEG_A | SEG_B | SEG_C | SEG_D | SEG_E | SEG_F);
    localparam logic [FTSD_W-1:0] FTSD_1 = ~(SEG_B | SEG_C);
    localparam logic [FTSD_W-1:0] FTSD_2 = ~(SEG_A | SEG_B | SEG_G1 | SEG_G2 | SEG_E | SEG_D);
    localparam logic [FTSD_W-1:0] FTSD_3 = ~(SEG_A | SEG_B | SEG_C | SEG_D | SEG_G1 | SEG_G2);
    localparam logic [FTSD_W-1:0] FTSD_4 = ~(SEG_F | SEG_G1 | SEG_G2 | SEG_B | SEG_C);
    localparam logic [FTSD_W-1:0] FTSD_5 = ~(SEG_A | SEG_F | SEG_G1 | SEG_G2 | SEG_C | SEG_D);
    localparam logic [FTSD_W-1:0] FTSD_6 = ~(SEG_A | SEG_F | SEG_E | SEG_D | SEG_C | SEG_G1 | SEG_G2);
    localparam logic [FTSD_W-1:0] FTSD_7 = ~(SEG_A | SEG_B | SEG_C);
    localparam logic [FTSD_W-1:0] FTSD_8 = ~(SEG_A | SEG_B | SEG_C | SEG_D | SEG_E | SEG_F |
                                             SEG_G1 | SEG_G2);
    localparam logic [FTSD_W-1:0] FTSD_9 = ~(SEG_A | SEG_B | SEG_C | SEG_D | SEG_F |
                                             SEG_G1 | SEG_G2);

endpackage

// File: rtl/bcd_to_ftsd.sv
// ---------------------------------------------------------------------------
// bcd_to_ftsd
// Combinational BCD digit to fourteen-segment glyph decoder.
// Ports:
//   bcd : 4-bit digit value
//   seg : active-low segment pattern; non-decimal codes 10..15 show a dash
// ---------------------------------------------------------------------------
module bcd_to_ftsd
    import ftsd_pkg::*;
(
    input  logic [3:0]        bcd,
    output logic [FTSD_W-1:0] seg
);

    always_comb begin
        seg = FTSD_DASH;
        case (bcd)
            4'd0:    seg = FTSD_0;
            4'd1:    seg = FTSD_1;
            4'd2:    seg = FTSD_2;
            4'd3:    seg = FTSD_3;
            4'd4:    seg = FTSD_4;
            4'd5:    seg = FTSD_5;
            4'd6:    seg = FTSD_6;
            4'd7:    seg = FTSD_7;
            4'd8:    seg = FTSD_8;
            4'd9:    seg = FTSD_9;
            default: seg = FTSD_DASH;
        endcase
    end

endmodule

// File: rtl/ftsd_scan4.sv
// ---------------------------------------------------------------------------
// ftsd_scan4
// Time-multiplexes a 4-digit BCD score onto the fourteen-segment display,
// with optional leading-zero blanking and a frame-locked blink.
// Ports:
//   clk        : system clock, the only clock
//   rst_n      : synchronous active-low reset
//   score      : four BCD digits, [3:0] rightmost (digit 0)
//   blink      : level; 1 blanks the whole display in the blink off phase
//   frame_done : one-cycle pulse as digit 3's slot ends
//   ftsd       : active-low segment bus
//   ftsd_ctl   : active-low one-hot digit enable
// Parameters:
//   SCAN_DIV     : clk cycles per digit slot (>= 2)
//   BLINK_FRAMES : full frames per blink half-period (>= 1)
//   LZ_BLANK     : 1 blanks leading zeros on digits 3..1
// ---------------------------------------------------------------------------
module ftsd_scan4
    import ftsd_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 125,
    parameter int LZ_BLANK     = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [15:0]       score,
    input  logic              blink,
    output logic              frame_done,
    output logic [FTSD_W-1:0] ftsd,
    output logic [3:0]        ftsd_ctl
);

    localparam int SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FRAME_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(BLINK_FRAMES - 1);

    logic [SCAN_W-1:0]  scan_cnt;
    logic [1:0]         idx;
    logic [15:0]        shadow;
    logic [FRAME_W-1:0] frame_cnt;
    logic               blink_on;

    logic               terminal;
    logic               frame_end;
    logic [3:0]         cur_digit;
    logic [FTSD_W-1:0]  dec_seg;
    logic [DIGITS-1:0]  zero_from;
    logic               lz_hit;
    logic [FTSD_W-1:0]  seg_next;

    assign terminal  = (scan_cnt == SCAN_LAST);
    assign frame_end = terminal && (idx == 2'd3);

    // Digits are always taken from the per-frame shadow copy, never from the
    // live score, so a score change can only show up at a frame boundary.
    assign cur_digit = shadow[{idx, 2'b00} +: 4];

    bcd_to_ftsd u_dec (
        .bcd (cur_digit),
        .seg (dec_seg)
    );

    // zero_from[i]: digit i and every digit above it are zero.
    always_comb begin
        zero_from = '0;
        zero_from[DIGITS-1] = (shadow[15:12] == 4'd0);
        for (int i = DIGITS - 2; i >= 0; i--) begin
            zero_from[i] = zero_from[i+1] && (shadow[i*4 +: 4] == 4'd0);
        end
    end

    // Digit 0 is excluded so a zero score still shows a single 0.
    assign lz_hit = (LZ_BLANK != 0) && (idx != 2'd0) && zero_from[idx];

    always_comb begin
        seg_next = dec_seg;
        if (blink && !blink_on) begin
            seg_next = FTSD_BLANK;
        end else if (lz_hit) begin
            seg_next = FTSD_BLANK;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scan_cnt   <= '0;
            idx        <= 2'd0;
            shadow     <= 16'h0000;
            frame_cnt  <= '0;
            blink_on   <= 1'b1;
            frame_done <= 1'b0;
            ftsd       <= FTSD_BLANK;
            ftsd_ctl   <= 4'b1111;
        end else begin
            frame_done <= frame_end;
            ftsd_ctl   <= ~(4'b0001 << idx);
            ftsd       <= seg_next;

            if (terminal) begin
                scan_cnt <= '0;
                idx      <= idx + 2'd1;
            end else begin
                scan_cnt <= scan_cnt + SCAN_W'(1);
            end

            // blink_on keeps toggling even with blink low, so turning blink
            // back on resumes in phase with the frame count.
            if (frame_end) begin
                shadow <= score;
                if (frame_cnt == FRAME_LAST) begin
                    frame_cnt <= '0;
                    blink_on  <= ~blink_on;
                end else begin
                    frame_cnt <= frame_cnt + FRAME_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_ftsd_scan4.sv
// Bench for ftsd_scan4 with SCAN_DIV=4, BLINK_FRAMES=2. Two instances share
// stimulus: dut_lz has leading-zero blanking on, dut_nolz has it off.
module tb_ftsd_scan4;
    import ftsd_pkg::*;

    localparam int SD        = 4;
    localparam int BF        = 2;
    localparam int FRAME_CYC = 4 * SD;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        blink = 1'b0;
    logic [15:0] score = 16'h1234;

    logic        a_fd, b_fd;
    logic [14:0] a_ftsd, b_ftsd;
    logic [3:0]  a_ctl, b_ctl;

    ftsd_scan4 #(.SCAN_DIV(SD), .BLINK_FRAMES(BF), .LZ_BLANK(1)) dut_lz (
        .clk(clk), .rst_n(rst_n), .score(score), .blink(blink),
        .frame_done(a_fd), .ftsd(a_ftsd), .ftsd_ctl(a_ctl));

    ftsd_scan4 #(.SCAN_DIV(SD), .BLINK_FRAMES(BF), .LZ_BLANK(0)) dut_nolz (
        .clk(clk), .rst_n(rst_n), .score(score), .blink(blink),
        .frame_done(b_fd), .ftsd(b_ftsd), .ftsd_ctl(b_ctl));

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  ctl;
        logic [14:0] seg_a;
        logic [14:0] seg_b;
    } exp_t;

    typedef struct packed {
        logic [15:0]      score;
        logic [3:0][14:0] ea;   // [d] = expected glyph for digit d, LZ on
        logic [3:0][14:0] eb;   // LZ off
    } vec_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   frames_since_rst = 0;
    exp_t sb_q[$];
    vec_t vecs[7];
    logic [3:0] ctl_tab[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic push_frame(input logic [3:0][14:0] ea, input logic [3:0][14:0] eb);
        exp_t e;
        for (int d = 0; d < 4; d++) begin
            e.ctl   = ctl_tab[d];
            e.seg_a = ea[d];
            e.seg_b = eb[d];
            sb_q.push_back(e);
        end
    endtask

    // Advance to the next frame_done pulse, bounded.
    task automatic wait_fd();
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (a_fd !== 1'b1 && k < 3 * FRAME_CYC);
        check("frame_done_wait", 32'(a_fd), 32'd1);
        frames_since_rst++;
    endtask

    // Called on the negedge where frame_done is seen; checks the 16 output
    // cycles of the following frame against the scoreboard.
    task automatic check_frame(input int chg_c, input logic [15:0] chg_score);
        exp_t e;
        e = '0;
        for (int c = 0; c < FRAME_CYC; c++) begin
            if (c % SD == 0) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL scoreboard_empty: got 0 entries, required 1 (t=%0t)", $time);
                end else begin
                    e = sb_q.pop_front();
                end
            end
            @(negedge clk);
            check("ctl_lz",    32'(a_ctl),  32'(e.ctl));
            check("ctl_nolz",  32'(b_ctl),  32'(e.ctl));
            check("ftsd_lz",   32'(a_ftsd), 32'(e.seg_a));
            check("ftsd_nolz", 32'(b_ftsd), 32'(e.seg_b));
            check("frame_done_lz",   32'(a_fd), 32'(c == FRAME_CYC - 1));
            check("frame_done_nolz", 32'(b_fd), 32'(c == FRAME_CYC - 1));
            if (c == chg_c) score = chg_score;
        end
        frames_since_rst++;
    endtask

    task automatic check_reset_outputs();
        @(negedge clk);
        check("rst_ftsd_lz",   32'(a_ftsd), 32'h7FFF);
        check("rst_ftsd_nolz", 32'(b_ftsd), 32'h7FFF);
        check("rst_ctl",       32'(a_ctl),  32'hF);
        check("rst_frame_done", 32'(a_fd | b_fd), 32'd0);
    endtask

    initial begin
        logic [14:0] s;

        ctl_tab[0] = 4'b1110;
        ctl_tab[1] = 4'b1101;
        ctl_tab[2] = 4'b1011;
        ctl_tab[3] = 4'b0111;

        //           score      ea {d3,d2,d1,d0}                              eb {d3,d2,d1,d0}
        vecs[0] = '{16'h1234, {FTSD_1, FTSD_2, FTSD_3, FTSD_4},             {FTSD_1, FTSD_2, FTSD_3, FTSD_4}};
        vecs[1] = '{16'h0050, {FTSD_BLANK, FTSD_BLANK, FTSD_5, FTSD_0},     {FTSD_0, FTSD_0, FTSD_5, FTSD_0}};
        vecs[2] = '{16'h9A0F, {FTSD_9, FTSD_DASH, FTSD_0, FTSD_DASH},       {FTSD_9, FTSD_DASH, FTSD_0, FTSD_DASH}};
        vecs[3] = '{16'h0000, {FTSD_BLANK, FTSD_BLANK, FTSD_BLANK, FTSD_0}, {FTSD_0, FTSD_0, FTSD_0, FTSD_0}};
        vecs[4] = '{16'h0009, {FTSD_BLANK, FTSD_BLANK, FTSD_BLANK, FTSD_9}, {FTSD_0, FTSD_0, FTSD_0, FTSD_9}};
        vecs[5] = '{16'h1000, {FTSD_1, FTSD_0, FTSD_0, FTSD_0},             {FTSD_1, FTSD_0, FTSD_0, FTSD_0}};
        vecs[6] = '{16'h0F87, {FTSD_BLANK, FTSD_DASH, FTSD_8, FTSD_7},      {FTSD_0, FTSD_DASH, FTSD_8, FTSD_7}};

        // Reset held 3 cycles with a non-zero score on the bus.
        rst_n = 1'b0;
        score = vecs[0].score;
        for (int i = 0; i < 3; i++) check_reset_outputs();
        rst_n = 1'b1;
        frames_since_rst = 0;

        // First frame shows the zero shadow; then the captured 1234.
        push_frame(vecs[3].ea, vecs[3].eb);
        check_frame(-1, 16'h0);
        push_frame(vecs[0].ea, vecs[0].eb);
        check_frame(-1, 16'h0);

        for (int i = 1; i < 7; i++) begin
            score = vecs[i].score;
            push_frame(vecs[i].ea, vecs[i].eb);
            wait_fd();
            check_frame(-1, 16'h0);
        end

        // Tear-free: switch to 2222 while digit 1 is showing.
        score = 16'h1111;
        push_frame({FTSD_1, FTSD_1, FTSD_1, FTSD_1}, {FTSD_1, FTSD_1, FTSD_1, FTSD_1});
        wait_fd();
        check_frame(5, 16'h2222);
        push_frame({FTSD_2, FTSD_2, FTSD_2, FTSD_2}, {FTSD_2, FTSD_2, FTSD_2, FTSD_2});
        check_frame(-1, 16'h0);

        // Mid-scan reset while idx = 2.
        for (int c = 0; c < 9; c++) @(negedge clk);
        rst_n = 1'b0;
        check_reset_outputs();
        rst_n = 1'b1;
        frames_since_rst = 0;
        push_frame(vecs[3].ea, vecs[3].eb);
        check_frame(-1, 16'h0);

        // Blink: shadow now holds 2222, blink_on phase is known from reset.
        blink = 1'b1;
        for (int k = 0; k < 5; k++) begin
            s = (((frames_since_rst / BF) % 2) == 0) ? FTSD_2 : FTSD_BLANK;
            push_frame({s, s, s, s}, {s, s, s, s});
            check_frame(-1, 16'h0);
        end

        // Off phase; drop blink partway through and expect digits next update.
        check("blink_phase_off", 32'((frames_since_rst / BF) % 2), 32'd1);
        for (int c = 0; c < FRAME_CYC; c++) begin
            @(negedge clk);
            s = (c <= 5) ? FTSD_BLANK : FTSD_2;
            check("unblink_ctl",  32'(a_ctl),  32'(ctl_tab[c / SD]));
            check("unblink_ftsd", 32'(a_ftsd), 32'(s));
            check("unblink_ftsd_nolz", 32'(b_ftsd), 32'(s));
            if (c == 5) blink = 1'b0;
        end

        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
